// File: rtl/frame_pkg.sv
// Shared definitions for the 16-bit framed bus: framing constants, FSM states and CRC-16 helper.
package frame_pkg;

  localparam logic [31:0] HEADER   = 32'hE0E0E0E0;
  localparam logic [31:0] TRAILER  = 32'h0E0E0E0E;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_CHAN,
    ST_DATA,
    ST_CRC,
    ST_TRL_HI,
    ST_TRL_LO
  } frame_state_t;

  // CRC-16/CCITT-FALSE step over one 16-bit word, MSB first, no reflection.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_tx_buf.sv
// Payload register file for the frame builder: one synchronous write port, combinational read.
module frame_tx_buf #(
  parameter int MAX_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [15:0]      rdata
);

  logic [15:0] mem [MAX_WORDS];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_builder.sv
// Buffers a 1..8 word payload, then emits header, channel word, data, CRC-16 and trailer as one gapless frame.
module frame_builder
  import frame_pkg::*;
#(
  parameter int          MAX_WORDS = 8,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  chan_sel,
  input  logic [2:0]  len_words,
  input  logic [15:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [15:0] data_out,
  output logic        data_out_vld,
  output logic        busy,
  output logic        frame_done,
  output logic        cfg_err
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  frame_state_t     state;
  logic [7:0]       chan_q;
  logic [2:0]       n_m1;
  logic [IDX_W-1:0] idx;
  logic [15:0]      crc_q;
  logic [15:0]      buf_rdata;
  logic             buf_we;
  logic             idx_last;

  assign buf_we   = (state == ST_LOAD) && pld_valid && pld_ready;
  assign idx_last = (idx == IDX_W'(n_m1));

  frame_tx_buf #(
    .MAX_WORDS (MAX_WORDS),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .we     (buf_we),
    .waddr  (idx),
    .wdata  (pld_data),
    .raddr  (idx),
    .rdata  (buf_rdata)
  );

  // Outputs are registered from the current state, so each word appears one edge after its state is entered.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      chan_q       <= '0;
      n_m1         <= '0;
      idx          <= '0;
      crc_q        <= '0;
      data_out     <= IDLE_WORD;
      data_out_vld <= 1'b0;
      pld_ready    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          data_out     <= IDLE_WORD;
          data_out_vld <= 1'b0;
          busy         <= 1'b0;
          if (start) begin
            if (chan_sel != 8'h00) begin
              chan_q    <= chan_sel;
              n_m1      <= len_words;
              idx       <= '0;
              pld_ready <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (buf_we) begin
            idx <= idx + 1'b1;
            if (idx_last) begin
              pld_ready <= 1'b0;
              crc_q     <= CRC_INIT;
              state     <= ST_HDR_HI;
            end
          end
        end
        ST_HDR_HI: begin
          data_out     <= HEADER[31:16];
          data_out_vld <= 1'b1;
          state        <= ST_HDR_LO;
        end
        ST_HDR_LO: begin
          data_out <= HEADER[15:0];
          state    <= ST_CHAN;
        end
        ST_CHAN: begin
          data_out <= {8'h00, chan_q};
          idx      <= '0;
          state    <= ST_DATA;
        end
        ST_DATA: begin
          data_out <= buf_rdata;
          crc_q    <= crc16_word(crc_q, buf_rdata);
          idx      <= idx + 1'b1;
          if (idx_last) state <= ST_CRC;
        end
        ST_CRC: begin
          data_out <= crc_q;
          state    <= ST_TRL_HI;
        end
        ST_TRL_HI: begin
          data_out <= TRAILER[31:16];
          state    <= ST_TRL_LO;
        end
        ST_TRL_LO: begin
          data_out   <= TRAILER[15:0];
          frame_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Randomized scoreboard bench for frame_builder: stimulus pushes expected frames, a monitor pops and compares.
module tb_frame_builder;

  localparam logic [15:0] IDLE_WORD = 16'h0000;

  logic        clk_in;
  logic        rst_n;
  logic        start;
  logic [7:0]  chan_sel;
  logic [2:0]  len_words;
  logic [15:0] pld_data;
  logic        pld_valid;
  logic        pld_ready;
  logic [15:0] data_out;
  logic        data_out_vld;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_word_q [$];
  bit          exp_last_q [$];
  bit          in_frame = 1'b0;
  logic [15:0] pld_arr [8];

  frame_builder #(
    .MAX_WORDS (8),
    .IDLE_WORD (IDLE_WORD)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .start        (start),
    .chan_sel     (chan_sel),
    .len_words    (len_words),
    .pld_data     (pld_data),
    .pld_valid    (pld_valid),
    .pld_ready    (pld_ready),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .busy         (busy),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Reference CRC: treat the payload as one MSB-first bit stream and divide bit by bit.
  function automatic logic [15:0] modelCrc(input int n);
    bit          bits [$];
    logic [15:0] r;
    bit          top;
    for (int w = 0; w < n; w++)
      for (int b = 15; b >= 0; b--) bits.push_back(pld_arr[w][b]);
    r = 16'hFFFF;
    foreach (bits[i]) begin
      top = r[15];
      r   = r << 1;
      if (top ^ bits[i]) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic pushWord(input logic [15:0] w, input bit last);
    exp_word_q.push_back(w);
    exp_last_q.push_back(last);
  endtask

  task automatic pushModelFrame(input logic [7:0] chan, input int n);
    pushWord(16'hE0E0, 1'b0);
    pushWord(16'hE0E0, 1'b0);
    pushWord({8'h00, chan}, 1'b0);
    for (int i = 0; i < n; i++) pushWord(pld_arr[i], 1'b0);
    pushWord(modelCrc(n), 1'b0);
    pushWord(16'h0E0E, 1'b0);
    pushWord(16'h0E0E, 1'b1);
  endtask

  // Monitor: every valid word must match the head of the scoreboard, and frames must be gapless.
  always @(negedge clk_in) begin : monitor
    logic [15:0] w;
    bit          l;
    if (data_out_vld) begin
      if (exp_word_q.size() == 0) begin
        flagFail($sformatf("unexpected_word actual=%h", data_out));
      end else begin
        w = exp_word_q.pop_front();
        l = exp_last_q.pop_front();
        checkOutput("frame_word", 32'(data_out), 32'(w));
        checkOutput("frame_done_pos", 32'(frame_done), 32'(l));
        in_frame = !l;
      end
    end else begin
      if (in_frame) begin
        flagFail("frame_gap");
        in_frame = 1'b0;
      end
      if (frame_done) flagFail("frame_done_without_valid");
    end
  end

  task automatic issueStart(input logic [7:0] chan, input logic [2:0] len, input bit use_model);
    if (use_model) pushModelFrame(chan, int'(len) + 1);
    start     = 1'b1;
    chan_sel  = chan;
    len_words = len;
    @(posedge clk_in); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Feeds N words; gap_mode 0 = always valid, 1 = every other cycle, 2 = random.
  task automatic loadPayload(input int n, input int gap_mode);
    int k = 0;
    int cyc = 0;
    bit toggle = 1'b1;
    bit v;
    while (k < n && cyc < 200) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       begin v = toggle; toggle = !toggle; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      checkOutput("pld_ready_load", 32'(pld_ready), 32'd1);
      pld_valid = v;
      pld_data  = v ? pld_arr[k] : 16'($urandom);
      @(posedge clk_in); #1;
      cyc++;
      if (v) k++;
    end
    pld_valid = 1'b0;
    if (k < n) flagFail("payload_timeout");
    checkOutput("pld_ready_drop", 32'(pld_ready), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] chan, input logic [2:0] len, input int gap_mode,
                               input bit use_model, input bit start_in_data);
    int cyc = 0;
    issueStart(chan, len, use_model);
    loadPayload(int'(len) + 1, gap_mode);
    if (start_in_data) begin
      repeat (3) @(posedge clk_in);
      #1;
      start     = 1'b1;
      chan_sel  = 8'($urandom_range(1, 255));
      len_words = 3'($urandom);
      @(posedge clk_in); #1;
      start = 1'b0;
    end
    while (!frame_done && cyc < 60) begin
      @(negedge clk_in);
      cyc++;
    end
    if (!frame_done) flagFail("frame_done_timeout");
    @(posedge clk_in); #1;
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    checkOutput("vld_after_frame", 32'(data_out_vld), 32'd0);
    checkOutput("idle_word_after_frame", 32'(data_out), 32'(IDLE_WORD));
    checkOutput("scoreboard_drained", 32'(exp_word_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    logic [7:0] ch;
    logic [2:0] ln;
    int         cyc;
    rst_n     = 1'b0;
    start     = 1'b0;
    chan_sel  = 8'h00;
    len_words = 3'd0;
    pld_data  = 16'h0000;
    pld_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_data_out", 32'(data_out), 32'(IDLE_WORD));
    checkOutput("reset_vld", 32'(data_out_vld), 32'd0);
    checkOutput("reset_pld_ready", 32'(pld_ready), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    $display("[TB] single-word frame with known CRC");
    pld_arr[0] = 16'h0000;
    pushWord(16'hE0E0, 1'b0);
    pushWord(16'hE0E0, 1'b0);
    pushWord(16'h0001, 1'b0);
    pushWord(16'h0000, 1'b0);
    pushWord(16'h1D0F, 1'b0);
    pushWord(16'h0E0E, 1'b0);
    pushWord(16'h0E0E, 1'b1);
    applyStimulus(8'h01, 3'd0, 0, 1'b0, 1'b0);

    $display("[TB] eight-word frame");
    for (int i = 0; i < 8; i++) pld_arr[i] = 16'h1111 * 16'(i + 1);
    applyStimulus(8'hA5, 3'd7, 0, 1'b1, 1'b0);

    $display("[TB] payload with valid toggling");
    for (int i = 0; i < 8; i++) pld_arr[i] = 16'($urandom);
    applyStimulus(8'h3C, 3'd5, 1, 1'b1, 1'b0);

    $display("[TB] zero channel mask rejected");
    start    = 1'b1;
    chan_sel = 8'h00;
    @(posedge clk_in); #1;
    start = 1'b0;
    checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd1);
    checkOutput("cfg_err_busy", 32'(busy), 32'd0);
    checkOutput("cfg_err_pld_ready", 32'(pld_ready), 32'd0);
    checkOutput("cfg_err_vld", 32'(data_out_vld), 32'd0);
    @(posedge clk_in); #1;
    checkOutput("cfg_err_clears", 32'(cfg_err), 32'd0);
    checkOutput("cfg_err_stays_idle", 32'(pld_ready), 32'd0);

    $display("[TB] payload valid outside load");
    pld_valid = 1'b1;
    pld_data  = 16'hBEEF;
    repeat (3) begin
      @(posedge clk_in); #1;
      checkOutput("idle_pld_ready", 32'(pld_ready), 32'd0);
      checkOutput("idle_vld", 32'(data_out_vld), 32'd0);
    end
    pld_valid = 1'b0;

    $display("[TB] start pulsed during data phase");
    for (int i = 0; i < 8; i++) pld_arr[i] = 16'($urandom);
    applyStimulus(8'h80, 3'd6, 0, 1'b1, 1'b1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 8; i++) pld_arr[i] = 16'($urandom);
      ch = 8'($urandom_range(1, 255));
      ln = 3'($urandom);
      applyStimulus(ch, ln, int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk_in);
      #1;
    end

    $display("[TB] reset during CRC state");
    for (int i = 0; i < 8; i++) pld_arr[i] = 16'($urandom);
    issueStart(8'h42, 3'd7, 1'b1);
    loadPayload(8, 0);
    repeat (3 + 8) @(posedge clk_in);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_vld", 32'(data_out_vld), 32'd0);
    checkOutput("midreset_data_out", 32'(data_out), 32'(IDLE_WORD));
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    exp_word_q.delete();
    exp_last_q.delete();
    in_frame = 1'b0;
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    @(posedge clk_in); #1;
    for (int i = 0; i < 8; i++) pld_arr[i] = 16'($urandom);
    applyStimulus(8'h07, 3'd3, 2, 1'b1, 1'b0);

    cyc = 0;
    repeat (5) begin
      @(posedge clk_in);
      cyc++;
    end
    #1;
    checkOutput("final_scoreboard_empty", 32'(exp_word_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_builder.md
# frame_builder

Transmit-side counterpart of the 16-bit framed input bus. Accepts a channel mask, a payload length and 1–8 payload words, buffers the complete payload, then emits one contiguous frame on a 16-bit word bus: header, channel word, data, CRC-16, trailer. It sits in front of the frame detector, on the same `clk_in` domain, and drives its `data_in` directly. It is used both for loopback tests and as the stimulus source for the detector.

## Interface
Parameters:
- `MAX_WORDS`, default 8: payload buffer depth, in 16-bit words.
- `IDLE_WORD`, default 16'h0000: value driven on `data_out` when no frame is being sent.

Ports:
- `clk_in` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: frame request. Sampled only in IDLE.
- `chan_sel` input, 8 bits: one-hot or multi-hot channel mask. Latched when `start` is accepted.
- `len_words` input, 3 bits: payload length N−1, giving N = 1..8 words (16..128 bits). Latched when `start` is accepted.
- `pld_data` input, 16 bits: payload word.
- `pld_valid` input, 1 bit: payload word valid.
- `pld_ready` output, 1 bit: the block can accept a payload word.
- `data_out` output, 16 bits: frame word stream.
- `data_out_vld` output, 1 bit: `data_out` carries a frame word.
- `busy` output, 1 bit: high from the cycle after `start` is accepted through the TRL_LO cycle.
- `frame_done` output, 1 bit: one-cycle pulse in the TRL_LO cycle.
- `cfg_err` output, 1 bit: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, LOAD, HDR_HI, HDR_LO, CHAN, DATA, CRC, TRL_HI, TRL_LO.
- IDLE:
  - `start`=1 with `chan_sel`≠0 → latch `chan_sel` and N, clear the word index, go to LOAD.
  - `start`=1 with `chan_sel`==0 → `cfg_err` pulse; stay in IDLE.
  - `start` is ignored in every other state.
- LOAD:
  - `pld_ready`=1.
  - Each `pld_valid`&&`pld_ready` cycle writes `pld_data` to buffer[idx] and increments idx.
  - When the Nth word is accepted, `pld_ready` drops the next cycle and the state moves to HDR_HI.
  - An indefinite `pld_valid` gap simply holds the block in LOAD.
- Emission, one word per cycle with `data_out_vld`=1:
  - HDR_HI drives 16'hE0E0; HDR_LO drives 16'hE0E0.
  - CHAN drives {8'h00, chan_sel}.
  - DATA drives buffer[0..N−1] in order, N cycles.
  - CRC drives the CRC word.
  - TRL_HI drives 16'h0E0E; TRL_LO drives 16'h0E0E; the state then returns to IDLE.
- CRC: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR), computed over the data words only.
  - Init to 0xFFFF on entering HDR_HI.
  - Update with each word driven in DATA.
  - The registered result is valid in the CRC state.
- IDLE and LOAD: `data_out`=`IDLE_WORD`, `data_out_vld`=0.

## Timing
- Reset values: state IDLE, `data_out`=`IDLE_WORD`, `data_out_vld`=0, `pld_ready`=0, `busy`=0, `frame_done`=0, `cfg_err`=0. Buffer contents, index and CRC register are all cleared.
- All outputs are registered; `data_out` changes only on `clk_in` rising edges.
- Latency: last payload handshake at edge t → HDR_HI word visible after edge t+1.
- Frame length is exactly N+6 consecutive valid cycles, with no gaps.
- Minimum frame spacing: TRL_LO → IDLE (1 cycle) → `start` → LOAD. Two frames are never adjacent.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously). A partial frame is truncated, never resumed.
- `pld_valid` asserted outside LOAD: no effect, because `pld_ready`=0.

## Structure
- Shared package `frame_pkg`:
  - HEADER = 32'hE0E0E0E0 and TRAILER = 32'h0E0E0E0E.
  - State enum `frame_state_t`.
  - CRC_POLY and CRC_INIT.
  - Function `crc16_word(crc, word)`: 16-bit parallel update.
  - The detector shares the same package.
- Sub-module `frame_tx_buf`: `MAX_WORDS`×16 register file with write port (we, waddr, wdata) and combinational read port (raddr → rdata). It is reset to 0.
- The top level holds the FSM, the index counter, the CRC register and the output registers.

## Test plan
- Reset, then `start`, `chan_sel`=8'h01, `len_words`=0, payload 16'h0000 → stream E0E0, E0E0, 0001, 0000, 1D0F, 0E0E, 0E0E; `frame_done` pulses on the last word.
- `len_words`=7, payload 0x1111..0x8888, `chan_sel`=8'hA5 → 14 contiguous valid words; CRC word matches the reference model.
- Payload with `pld_valid` toggled every other cycle → block stays in LOAD until word N; the emitted frame is still gapless.
- `start` with `chan_sel`=0 → `cfg_err` pulse; `busy`, `pld_ready` and `data_out_vld` stay 0.
- `start` pulsed during DATA → ignored; the frame completes unchanged.
- `rst_n` low during the CRC state → `data_out_vld`=0 and `data_out`=`IDLE_WORD` immediately; the next frame after release is correct.
- Loopback into the frame detector with `len_words`=7 → detector reaches TRAILER2, asserts `crc_valid` and drives the selected channel.
